dram_cmd_scheduler: RTL and testbench

DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

---
 rtl/dram_cmd_scheduler.sv | 168 ++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// DRAM command scheduler: separate read/write queues, RAW forwarding, WAR stalls and
// a write-drain mode, all feeding one registered command slot toward the DRAM side.
module dram_cmd_scheduler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_rw,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_cmd_rw,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [DATA_W-1:0] o_cmd_wdata,
  output logic              o_fwd_valid,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic [15:0]       o_wr_issued,
  output logic [15:0]       o_rd_issued,
  output logic [15:0]       o_raw_count
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  typedef enum logic {RD_PRI, WR_DRAIN} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_RD, SEL_WR} sel_t;

  state_t state, state_nxt;
  sel_t   sel;

  logic [ADDR_W-1:0] wq_addr [QDEPTH];
  logic [DATA_W-1:0] wq_data [QDEPTH];
  logic [ADDR_W-1:0] rq_addr [QDEPTH];
  logic [PTR_W-1:0]  wq_head, wq_tail, rq_head, rq_tail;
  logic [CNT_W-1:0]  wq_cnt, rq_cnt, wq_cnt_nxt;

  logic              slot_valid, slot_rw;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;

  logic              war_hit, raw_hit;
  logic [DATA_W-1:0] raw_data;
  logic              accept, wq_push, rq_push, fwd_take;
  logic              wq_pop, rq_pop, slot_free, handshake;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Hazard scan walks each queue oldest to youngest, so the last write match wins.
  always_comb begin
    logic [PTR_W-1:0] wi, ri;
    // NOTE: every combinational output is given a default first so no path infers a latch.
    wi       = '0;
    ri       = '0;
    war_hit  = slot_valid && !slot_rw && (slot_addr == i_req_addr);
    raw_hit  = slot_valid &&  slot_rw && (slot_addr == i_req_addr);
    raw_data = slot_wdata;
    for (int k = 0; k < QDEPTH; k++) begin
      wi = PTR_W'((int'(wq_head) + k) % QDEPTH);
      ri = PTR_W'((int'(rq_head) + k) % QDEPTH);
      if (k < int'(wq_cnt) && wq_addr[wi] == i_req_addr) begin
        raw_hit  = 1'b1;
        raw_data = wq_data[wi];
      end
      if (k < int'(rq_cnt) && rq_addr[ri] == i_req_addr) war_hit = 1'b1;
    end
  end

  always_comb begin
    o_req_ready = i_req_rw ? ((wq_cnt != CNT_W'(QDEPTH)) && !war_hit)
                           : (raw_hit || (rq_cnt != CNT_W'(QDEPTH)));
    accept   = i_req_valid && o_req_ready;
    wq_push  = accept && i_req_rw;
    rq_push  = accept && !i_req_rw && !raw_hit;
    fwd_take = accept && !i_req_rw && raw_hit;

    handshake = slot_valid && i_cmd_ready;
    slot_free = !slot_valid || handshake;

    sel = SEL_NONE;
    if (state == RD_PRI && rq_cnt != '0) sel = SEL_RD;
    else if (wq_cnt != '0)               sel = SEL_WR;
    wq_pop = slot_free && (sel == SEL_WR);
    rq_pop = slot_free && (sel == SEL_RD);

    wq_cnt_nxt = wq_cnt + CNT_W'(wq_push) - CNT_W'(wq_pop);
    state_nxt  = state;
    case (state)
      RD_PRI:   if (wq_cnt_nxt == CNT_W'(QDEPTH)) state_nxt = WR_DRAIN;
      WR_DRAIN: if (wq_cnt_nxt == '0)             state_nxt = RD_PRI;
      default:  state_nxt = RD_PRI;
    endcase
  end

  // NOTE: non-blocking assignments make every register update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= RD_PRI;
      wq_head     <= '0;
      wq_tail     <= '0;
      wq_cnt      <= '0;
      rq_head     <= '0;
      rq_tail     <= '0;
      rq_cnt      <= '0;
      slot_valid  <= 1'b0;
      slot_rw     <= 1'b0;
      slot_addr   <= '0;
      slot_wdata  <= '0;
      o_fwd_valid <= 1'b0;
      o_fwd_data  <= '0;
      o_wr_issued <= '0;
      o_rd_issued <= '0;
      o_raw_count <= '0;
    end else begin
      state  <= state_nxt;
      wq_cnt <= wq_cnt_nxt;
      rq_cnt <= rq_cnt + CNT_W'(rq_push) - CNT_W'(rq_pop);
      if (wq_push) wq_tail <= ptr_inc(wq_tail);
      if (wq_pop)  wq_head <= ptr_inc(wq_head);
      if (rq_push) rq_tail <= ptr_inc(rq_tail);
      if (rq_pop)  rq_head <= ptr_inc(rq_head);

      if (slot_free) begin
        slot_valid <= (sel != SEL_NONE);
        if (sel == SEL_WR) begin
          slot_rw    <= 1'b1;
          slot_addr  <= wq_addr[wq_head];
          slot_wdata <= wq_data[wq_head];
        end else if (sel == SEL_RD) begin
          slot_rw    <= 1'b0;
          slot_addr  <= rq_addr[rq_head];
          slot_wdata <= '0;
        end
      end

      if (handshake) begin
        if (slot_rw) o_wr_issued <= o_wr_issued + 16'd1;
        else         o_rd_issued <= o_rd_issued + 16'd1;
      end

      o_fwd_valid <= fwd_take;
      if (fwd_take) begin
        o_fwd_data  <= raw_data;
        o_raw_count <= o_raw_count + 16'd1;
      end
    end
  end

  // NOTE: queue storage is not reset; pointers and counts decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (wq_push) begin
      wq_addr[wq_tail] <= i_req_addr;
      wq_data[wq_tail] <= i_req_wdata;
    end
    if (rq_push) rq_addr[rq_tail] <= i_req_addr;
  end

  assign o_cmd_valid = slot_valid;
  assign o_cmd_rw    = slot_rw;
  assign o_cmd_addr  = slot_addr;
  assign o_cmd_wdata = slot_wdata;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_dram_cmd_scheduler;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int QDEPTH = 4;

  logic              i_clk, i_rst;
  logic              i_req_valid, o_req_ready, i_req_rw;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_cmd_valid, i_cmd_ready, o_cmd_rw;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic [DATA_W-1:0] o_cmd_wdata;
  logic              o_fwd_valid;
  logic [DATA_W-1:0] o_fwd_data;
  logic [15:0]       o_wr_issued, o_rd_issued, o_raw_count;

  dram_cmd_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rw(i_req_rw),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_rw(o_cmd_rw),
    .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata),
    .o_fwd_valid(o_fwd_valid), .o_fwd_data(o_fwd_data),
    .o_wr_issued(o_wr_issued), .o_rd_issued(o_rd_issued), .o_raw_count(o_raw_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: queues of pending commands plus the slot and drain flag.
  wr_t               m_wq[$];
  logic [ADDR_W-1:0] m_rq[$];
  bit                m_slot_v, m_slot_rw, m_drain, m_fwd_v;
  logic [ADDR_W-1:0] m_slot_addr;
  logic [DATA_W-1:0] m_slot_data, m_fwd_d;
  logic [15:0]       m_wr, m_rd, m_raw;
  logic [ADDR_W-1:0] issue_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_wq.delete();
    m_rq.delete();
    m_slot_v = 0; m_slot_rw = 0; m_slot_addr = '0; m_slot_data = '0;
    m_drain = 0; m_fwd_v = 0; m_fwd_d = '0;
    m_wr = '0; m_rd = '0; m_raw = '0;
  endtask

  // Acceptance decision for the request currently on the inputs.
  task automatic model_comb(output bit rdy, output bit hit, output logic [DATA_W-1:0] hd);
    bit war = 0;
    hit = 0;
    hd  = '0;
    if (i_req_rw) begin
      foreach (m_rq[i]) if (m_rq[i] == i_req_addr) war = 1;
      if (m_slot_v && !m_slot_rw && m_slot_addr == i_req_addr) war = 1;
      rdy = (m_wq.size() < QDEPTH) && !war;
    end else begin
      for (int i = m_wq.size() - 1; i >= 0 && !hit; i--)
        if (m_wq[i].addr == i_req_addr) begin hit = 1; hd = m_wq[i].data; end
      if (!hit && m_slot_v && m_slot_rw && m_slot_addr == i_req_addr) begin
        hit = 1; hd = m_slot_data;
      end
      rdy = hit || (m_rq.size() < QDEPTH);
    end
  endtask

  task automatic model_edge(input bit rdy, input bit hit, input logic [DATA_W-1:0] hd);
    bit hs = m_slot_v && i_cmd_ready;
    bit acc = i_req_valid && rdy;
    wr_t w;
    if (hs) begin
      if (m_slot_rw) m_wr++;
      else           m_rd++;
    end
    if (!m_slot_v || hs) begin
      if (!m_drain && m_rq.size() > 0) begin
        m_slot_v = 1; m_slot_rw = 0; m_slot_addr = m_rq.pop_front(); m_slot_data = '0;
      end else if (m_wq.size() > 0) begin
        w = m_wq.pop_front();
        m_slot_v = 1; m_slot_rw = 1; m_slot_addr = w.addr; m_slot_data = w.data;
      end else begin
        m_slot_v = 0;
      end
    end
    m_fwd_v = acc && !i_req_rw && hit;
    if (acc && i_req_rw) m_wq.push_back('{i_req_addr, i_req_wdata});
    else if (acc && !hit) m_rq.push_back(i_req_addr);
    if (m_fwd_v) begin m_fwd_d = hd; m_raw++; end
    if (!m_drain && m_wq.size() == QDEPTH) m_drain = 1;
    else if (m_drain && m_wq.size() == 0) m_drain = 0;
  endtask

  task automatic check_outputs();
    check("cmd_valid", o_cmd_valid, m_slot_v);
    if (m_slot_v) begin
      check("cmd_rw", o_cmd_rw, m_slot_rw);
      check("cmd_addr", o_cmd_addr, m_slot_addr);
      if (m_slot_rw) check("cmd_wdata", o_cmd_wdata, m_slot_data);
    end
    check("fwd_valid", o_fwd_valid, m_fwd_v);
    if (m_fwd_v) check("fwd_data", o_fwd_data, m_fwd_d);
    check("wr_issued", o_wr_issued, m_wr);
    check("rd_issued", o_rd_issued, m_rd);
    check("raw_count", o_raw_count, m_raw);
  endtask

  // One clock cycle: drive at negedge, check ready, clock the model, check registered outputs.
  task automatic step(input bit v, input bit rw, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit cr);
    bit rdy, hit;
    logic [DATA_W-1:0] hd;
    @(negedge i_clk);
    i_req_valid = v; i_req_rw = rw; i_req_addr = a; i_req_wdata = d; i_cmd_ready = cr;
    #1;
    model_comb(rdy, hit, hd);
    check("req_ready", o_req_ready, rdy);
    if (o_cmd_valid && i_cmd_ready) issue_log.push_back(o_cmd_addr);
    @(posedge i_clk);
    model_edge(rdy, hit, hd);
    #1;
    check_outputs();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cmd_valid"}, o_cmd_valid, 0);
    check({tag, "_fwd_valid"}, o_fwd_valid, 0);
    check({tag, "_cmd_rw"}, o_cmd_rw, 0);
    check({tag, "_cmd_addr"}, o_cmd_addr, 0);
    check({tag, "_cmd_wdata"}, o_cmd_wdata, 0);
    check({tag, "_fwd_data"}, o_fwd_data, 0);
    check({tag, "_wr_issued"}, o_wr_issued, 0);
    check({tag, "_rd_issued"}, o_rd_issued, 0);
    check({tag, "_raw_count"}, o_raw_count, 0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases mid high phase.
  task automatic do_reset(input string tag);
    #2;
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    #1;
    reset_checks(tag);
    model_clear();
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] exp_order [6];
    int pct [6];
    exp_order = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0050};
    pct = '{20, 90, 50, 5, 70, 40};

    i_rst = 1'b1; i_req_valid = 0; i_req_rw = 0; i_req_addr = '0; i_req_wdata = '0;
    i_cmd_ready = 0;
    model_clear();
    #2 reset_checks("por");
    @(posedge i_clk);
    #2 i_rst = 1'b0;

    // Single write, first cycle after reset release, issued with ready held high.
    step(1, 1, 16'h0010, 32'hA5A5_A5A5, 1);
    check("w1_latency_valid", o_cmd_valid, 0);
    step(0, 0, 16'h0000, 32'h0, 1);
    check("w1_valid", o_cmd_valid, 1);
    check("w1_rw", o_cmd_rw, 1);
    check("w1_addr", o_cmd_addr, 16'h0010);
    step(0, 0, 16'h0000, 32'h0, 1);
    check("w1_wr_issued", o_wr_issued, 1);

    // RAW forwarding returns the youngest matching write.
    do_reset("rst_raw");
    step(1, 1, 16'h0020, 32'h11, 0);
    step(1, 1, 16'h0020, 32'h22, 0);
    step(1, 0, 16'h0020, 32'h0, 0);
    check("raw_fwd_valid", o_fwd_valid, 1);
    check("raw_fwd_data", o_fwd_data, 32'h22);
    check("raw_count", o_raw_count, 1);
    step(0, 0, 16'h0000, 32'h0, 0);
    check("raw_pulse_end", o_fwd_valid, 0);
    check("raw_no_rd_issue", o_rd_issued, 0);

    // Write FIFO fills (one write already parked in the slot) and forces the drain mode.
    do_reset("rst_drain");
    for (int i = 0; i < 5; i++) step(1, 1, 16'h0040 + 16'(i), 32'(i), 0);
    step(1, 0, 16'h0050, 32'h0, 0);
    issue_log.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 16'h0000, 32'h0, 1);
    check("drain_count", issue_log.size(), 6);
    for (int i = 0; i < 6 && i < issue_log.size(); i++) check("drain_order", issue_log[i], exp_order[i]);
    check("drain_wr_issued", o_wr_issued, 5);
    check("drain_rd_issued", o_rd_issued, 1);

    // WAR stall: write to an address held by a pending read waits for its handshake.
    do_reset("rst_war");
    step(1, 0, 16'h0030, 32'h0, 0);
    step(0, 0, 16'h0000, 32'h0, 0);
    step(1, 1, 16'h0030, 32'h77, 0);
    check("war_stall_a", o_req_ready, 0);
    step(1, 1, 16'h0030, 32'h77, 0);
    check("war_stall_b", o_req_ready, 0);
    step(1, 1, 16'h0030, 32'h77, 1);
    check("war_release", o_req_ready, 1);
    step(1, 1, 16'h0030, 32'h77, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 32'h0, 1);
    check("war_wr_issued", o_wr_issued, 1);
    check("war_rd_issued", o_rd_issued, 1);

    // Reset with commands queued discards them.
    do_reset("rst_pre");
    for (int i = 0; i < 3; i++) step(1, 1, 16'h0060 + 16'(i), 32'(i), 0);
    do_reset("rst_mid");
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 32'h0, 1);
    check("rst_mid_wr_issued", o_wr_issued, 0);
    check("rst_mid_valid", o_cmd_valid, 0);

    // Randomized traffic over a tiny address set so hazards are frequent.
    do_reset("rst_rand");
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 399) == 0) do_reset("rst_rand_mid");
        step($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
             16'h0100 + 16'($urandom_range(0, 3)), $urandom,
             $urandom_range(0, 99) < pct[p]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
